// File: rtl/outfifo_rr_arbiter.sv
// Round-robin arbiter between per-thread output FIFOs and the single output port.
// One thread owns the port at a time. Ownership changes only at packet boundaries,
// and only after a minimum gap since the previous grant. Rotation is either strict
// in-order or work-conserving, which skips threads that have nothing pending.
module outfifo_rr_arbiter #(
   parameter int NUM_THREADS  = 8,
   parameter int DATA_WIDTH   = 64,
   parameter int CTRL_WIDTH   = 8,
   parameter bit STRICT_ORDER = 1'b1,
   parameter int GAP_CYCLES   = 3,
   parameter int PTR_WIDTH    = 3
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_THREADS-1:0]            thread_done,
   input  logic [NUM_THREADS*DATA_WIDTH-1:0] df_out_data_in,
   input  logic [NUM_THREADS*CTRL_WIDTH-1:0] df_out_ctrl_in,
   input  logic [NUM_THREADS-1:0]            df_out_wr_in,
   input  logic [NUM_THREADS-1:0]            df_out_wr_early_in,
   input  logic                              out_rdy,
   output logic [DATA_WIDTH-1:0]             out_data_out,
   output logic [CTRL_WIDTH-1:0]             out_ctrl_out,
   output logic                              out_wr_out,
   output logic [NUM_THREADS-1:0]            fifo_start_read,
   output logic [NUM_THREADS-1:0]            fifo_read_done,
   output logic [PTR_WIDTH-1:0]              cur_thread,
   output logic                              owner_valid
);

   typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

   localparam logic [3:0] GAP_LIM = 4'(GAP_CYCLES);

   state_t                 state, state_nxt;
   logic [NUM_THREADS-1:0] pending;
   logic [3:0]             gap_cnt;
   logic                   out_rdy_q;
   logic                   out_rdy_d;
   logic                   gap_ok;
   logic [PTR_WIDTH-1:0]   nxt;
   logic                   nxt_ok;
   logic [PTR_WIDTH-1:0]   idle_cand;
   logic                   idle_ok;
   logic                   do_grant;
   logic                   do_handoff;
   logic [PTR_WIDTH-1:0]   tgt;
   logic [NUM_THREADS-1:0] tgt_mask;

   // Index that is 'step' positions after 'base', wrapping modulo NUM_THREADS
   function automatic logic [PTR_WIDTH-1:0] wrap_inc(input logic [PTR_WIDTH-1:0] base,
                                                     input int step);
      int s;
      s = (int'(base) + step) % NUM_THREADS;
      return PTR_WIDTH'(s);
   endfunction

   function automatic logic [NUM_THREADS-1:0] onehot(input logic [PTR_WIDTH-1:0] idx);
      logic [NUM_THREADS-1:0] m;
      m      = '0;
      m[idx] = 1'b1;
      return m;
   endfunction

   // A one-cycle dip in out_rdy is tolerated: the registered copy covers it
   assign out_rdy_d = out_rdy | out_rdy_q;
   assign gap_ok    = (gap_cnt >= GAP_LIM);

   // Choose the next owner during XFER, and the first owner while IDLE.
   // The downward loop lets the nearest pending thread win.
   // In work-conserving mode the current owner is searched last (k = NUM_THREADS).
   always_comb begin
      nxt       = wrap_inc(cur_thread, 1);
      nxt_ok    = 1'b0;
      idle_cand = '0;
      idle_ok   = 1'b0;
      if (STRICT_ORDER) begin
         nxt_ok  = pending[nxt];
         idle_ok = pending[0];
      end else begin
         for (int k = NUM_THREADS; k >= 1; k--) begin
            if (pending[wrap_inc(cur_thread, k)]) begin
               nxt    = wrap_inc(cur_thread, k);
               nxt_ok = 1'b1;
            end
         end
         for (int i = NUM_THREADS - 1; i >= 0; i--) begin
            if (pending[i]) begin
               idle_cand = PTR_WIDTH'(i);
               idle_ok   = 1'b1;
            end
         end
      end
   end

   // Next-state logic: first grant out of IDLE, and handoff only at a packet boundary
   always_comb begin
      state_nxt  = state;
      do_grant   = 1'b0;
      do_handoff = 1'b0;
      case (state)
         IDLE: begin
            if (idle_ok) begin
               do_grant  = 1'b1;
               state_nxt = XFER;
            end
         end
         XFER: begin
            if (gap_ok && !df_out_wr_early_in[cur_thread] && out_rdy_d && nxt_ok)
               do_handoff = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign tgt      = do_grant ? idle_cand : nxt;
   assign tgt_mask = (do_grant || do_handoff) ? onehot(tgt) : '0;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Owner pointer, grant/release pulses and gap counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur_thread      <= '0;
         owner_valid     <= 1'b0;
         gap_cnt         <= '0;
         out_rdy_q       <= 1'b0;
         fifo_start_read <= '0;
         fifo_read_done  <= '0;
      end else begin
         out_rdy_q       <= out_rdy;
         fifo_start_read <= tgt_mask;
         fifo_read_done  <= do_handoff ? onehot(cur_thread) : '0;
         if (do_grant || do_handoff) begin
            cur_thread  <= tgt;
            owner_valid <= 1'b1;
            gap_cnt     <= '0;
         end else if (gap_cnt != 4'hF) begin
            gap_cnt <= gap_cnt + 4'd1;
         end
      end
   end

   // Pending requests: a new thread_done wins over the clear caused by its own grant
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) pending <= '0;
      else        pending <= (pending & ~tgt_mask) | thread_done;
   end

   // Output mux: pass the owner's stream through with zero latency, held at 0 while idle
   always_comb begin
      out_data_out = '0;
      out_ctrl_out = '0;
      out_wr_out   = 1'b0;
      if (state == XFER) begin
         out_data_out = df_out_data_in[int'(cur_thread) * DATA_WIDTH +: DATA_WIDTH];
         out_ctrl_out = df_out_ctrl_in[int'(cur_thread) * CTRL_WIDTH +: CTRL_WIDTH];
         out_wr_out   = df_out_wr_in[cur_thread];
      end
   end

endmodule

// File: tb/tb_outfifo_rr_arbiter.sv
// Bench for outfifo_rr_arbiter: one strict-order instance and one work-conserving
// instance share the same stimulus. A scoreboard of expected grant/release pulses is
// checked against whichever instance the current step selects.
module tb_outfifo_rr_arbiter;
   localparam int N   = 8;
   localparam int DW  = 64;
   localparam int CW  = 8;
   localparam int PW  = 3;
   localparam int GAP = 3;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    thread_done;
   logic [N*DW-1:0] df_data;
   logic [N*CW-1:0] df_ctrl;
   logic [N-1:0]    df_wr;
   logic [N-1:0]    df_wr_early;
   logic            out_rdy;

   logic [DW-1:0] data_st, data_rr, m_data;
   logic [CW-1:0] ctrl_st, ctrl_rr, m_ctrl;
   logic          wr_st, wr_rr, m_wr;
   logic [N-1:0]  sr_st, sr_rr, m_sr;
   logic [N-1:0]  rd_st, rd_rr, m_rd;
   logic [PW-1:0] cur_st, cur_rr, m_cur;
   logic          ov_st, ov_rr, m_ov;
   logic          sel_rr;

   typedef struct {
      logic [N-1:0]  sr;
      logic [N-1:0]  rd;
      logic [PW-1:0] cur;
      int            dly;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   last_cyc = 0;

   outfifo_rr_arbiter #(.NUM_THREADS(N), .DATA_WIDTH(DW), .CTRL_WIDTH(CW),
                        .STRICT_ORDER(1'b1), .GAP_CYCLES(GAP), .PTR_WIDTH(PW)) u_st (
      .clk(clk), .reset(reset), .thread_done(thread_done),
      .df_out_data_in(df_data), .df_out_ctrl_in(df_ctrl), .df_out_wr_in(df_wr),
      .df_out_wr_early_in(df_wr_early), .out_rdy(out_rdy),
      .out_data_out(data_st), .out_ctrl_out(ctrl_st), .out_wr_out(wr_st),
      .fifo_start_read(sr_st), .fifo_read_done(rd_st),
      .cur_thread(cur_st), .owner_valid(ov_st));

   outfifo_rr_arbiter #(.NUM_THREADS(N), .DATA_WIDTH(DW), .CTRL_WIDTH(CW),
                        .STRICT_ORDER(1'b0), .GAP_CYCLES(GAP), .PTR_WIDTH(PW)) u_rr (
      .clk(clk), .reset(reset), .thread_done(thread_done),
      .df_out_data_in(df_data), .df_out_ctrl_in(df_ctrl), .df_out_wr_in(df_wr),
      .df_out_wr_early_in(df_wr_early), .out_rdy(out_rdy),
      .out_data_out(data_rr), .out_ctrl_out(ctrl_rr), .out_wr_out(wr_rr),
      .fifo_start_read(sr_rr), .fifo_read_done(rd_rr),
      .cur_thread(cur_rr), .owner_valid(ov_rr));

   assign m_data = sel_rr ? data_rr : data_st;
   assign m_ctrl = sel_rr ? ctrl_rr : ctrl_st;
   assign m_wr   = sel_rr ? wr_rr   : wr_st;
   assign m_sr   = sel_rr ? sr_rr   : sr_st;
   assign m_rd   = sel_rr ? rd_rr   : rd_st;
   assign m_cur  = sel_rr ? cur_rr  : cur_st;
   assign m_ov   = sel_rr ? ov_rr   : ov_st;

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] tdata(input int i);
      return 64'h1111_1111_1111_1111 * 64'(i + 1);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic push(input logic [N-1:0] sr, input logic [N-1:0] rd,
                       input logic [PW-1:0] cur, input int dly);
      exp_t e;
      e.sr = sr; e.rd = rd; e.cur = cur; e.dly = dly;
      exp_q.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic use_rr);
      reset       = 1'b0;
      thread_done = '0;
      df_wr       = '0;
      df_wr_early = '0;
      out_rdy     = 1'b1;
      sel_rr      = use_rr;
      exp_q.delete();
      tick(2);
      reset    = 1'b1;
      last_cyc = cyc;
   endtask

   task automatic wait_drain(input string tag, input int max);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < max) begin
         tick(1);
         k++;
      end
      chk(tag, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   // Cycle counter
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Scoreboard monitor: every observed grant pops one expected entry
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (reset === 1'b1) begin
         if (m_sr != '0) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_start_read", 64'(m_sr), 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk("sb_start_read", 64'(m_sr), 64'(e.sr));
               chk("sb_read_done", 64'(m_rd), 64'(e.rd));
               chk("sb_cur_thread", 64'(m_cur), 64'(e.cur));
               if (e.dly != 0) chk("sb_grant_gap", 64'(cyc - last_cyc), 64'(e.dly));
            end
            last_cyc = cyc;
         end else if (m_rd != '0) begin
            chk("orphan_read_done", 64'(m_rd), 64'd0);
         end
      end
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < N; i++) begin
         df_data[i*DW +: DW] = tdata(i);
         df_ctrl[i*CW +: CW] = 8'h10 + 8'(i);
      end
      reset = 1'b0; thread_done = '0; df_wr = '0; df_wr_early = '0; out_rdy = 1'b1;
      sel_rr = 1'b0;

      // Reset state and first grant (strict instance)
      reset = 1'b0; exp_q.delete();
      tick(2);
      chk("rst_cur_thread", 64'(m_cur), 64'd0);
      chk("rst_owner_valid", 64'(m_ov), 64'd0);
      chk("rst_start_read", 64'(m_sr), 64'd0);
      chk("rst_read_done", 64'(m_rd), 64'd0);
      chk("rst_out_wr", 64'(m_wr), 64'd0);
      chk("rst_out_data", m_data, 64'd0);
      reset = 1'b1; last_cyc = cyc;
      thread_done = 8'h01;
      push(8'h01, 8'h00, 3'd0, 0);
      tick(1);
      thread_done = '0;
      #1 chk("t1_no_start_yet", 64'(m_sr), 64'd0);
      tick(1);
      chk("t1_start_read", 64'(m_sr), 64'h01);
      chk("t1_cur_thread", 64'(m_cur), 64'd0);
      chk("t1_owner_valid", 64'(m_ov), 64'd1);
      df_wr = 8'h01;
      #1;
      chk("t1_out_wr", 64'(m_wr), 64'd1);
      chk("t1_out_data", m_data, tdata(0));
      chk("t1_out_ctrl", 64'(m_ctrl), 64'h10);
      tick(1);
      df_wr = '0;
      chk("t1_pulse_width", 64'(m_sr), 64'd0);

      // Strict order: thread 2 pending cannot jump ahead of thread 1
      thread_done = 8'h04;
      tick(1);
      thread_done = '0;
      tick(6);
      chk("t2_hold_owner0", 64'(m_cur), 64'd0);
      thread_done = 8'h02;
      push(8'h02, 8'h01, 3'd1, 0);
      push(8'h04, 8'h02, 3'd2, GAP + 1);
      tick(1);
      thread_done = '0;
      wait_drain("t2_drain", 20);
      chk("t2_final_owner", 64'(m_cur), 64'd2);

      // Work-conserving: owner 1, pending {5,6}; threads 2-4 skipped
      do_reset(1'b1);
      thread_done = 8'h02;
      push(8'h02, 8'h00, 3'd1, 0);
      tick(1);
      thread_done = '0;
      tick(1);
      thread_done = 8'h60;
      push(8'h20, 8'h02, 3'd5, GAP + 1);
      push(8'h40, 8'h20, 3'd6, GAP + 1);
      tick(1);
      thread_done = '0;
      wait_drain("t3_drain", 20);
      chk("t3_owner6", 64'(m_cur), 64'd6);
      // Only the owner itself pending: release and regrant of the same thread
      thread_done = 8'h40;
      push(8'h40, 8'h40, 3'd6, GAP + 1);
      tick(1);
      thread_done = '0;
      wait_drain("t3_self_drain", 20);

      // Packet integrity: no handoff while the owner is still emitting
      do_reset(1'b1);
      thread_done = 8'h08;
      push(8'h08, 8'h00, 3'd3, 0);
      tick(1);
      thread_done = '0;
      tick(1);
      df_wr_early = 8'h08;
      thread_done = 8'h10;
      push(8'h10, 8'h08, 3'd4, 0);
      tick(1);
      thread_done = '0;
      for (int c = 0; c < 10; c++) begin
         df_wr       = 8'($urandom);
         df_wr_early = 8'($urandom) | 8'h08;
         #1;
         chk("t4_wr_mirror", 64'(m_wr), 64'(df_wr[3]));
         chk("t4_data_mux", m_data, tdata(3));
         chk("t4_owner_hold", 64'(m_cur), 64'd3);
         tick(1);
      end
      df_wr       = 8'h10;
      df_wr_early = '0;
      tick(1);
      chk("t4_handoff_owner", 64'(m_cur), 64'd4);
      chk("t4_new_mux_wr", 64'(m_wr), 64'd1);
      chk("t4_new_mux_data", m_data, tdata(4));
      df_wr = '0;
      wait_drain("t4_drain", 10);

      // out_rdy: a long dip stalls the handoff, a one-cycle dip does not
      do_reset(1'b1);
      thread_done = 8'h01;
      push(8'h01, 8'h00, 3'd0, 0);
      tick(1);
      thread_done = '0;
      tick(1);
      out_rdy = 1'b0;
      tick(2);
      thread_done = 8'h02;
      tick(1);
      thread_done = '0;
      for (int c = 0; c < 6; c++) begin
         chk("t5_stall", 64'(m_cur), 64'd0);
         tick(1);
      end
      push(8'h02, 8'h01, 3'd1, 0);
      out_rdy = 1'b1;
      tick(1);
      chk("t5_resume_owner", 64'(m_cur), 64'd1);
      wait_drain("t5_resume_drain", 10);
      tick(5);
      thread_done = 8'h04;
      push(8'h04, 8'h02, 3'd2, 0);
      tick(1);
      thread_done = '0;
      out_rdy     = 1'b0;
      tick(1);
      out_rdy = 1'b1;
      chk("t5_dip_handoff", 64'(m_cur), 64'd2);
      wait_drain("t5_dip_drain", 10);

      // thread_done on the same edge as its own grant keeps the request
      do_reset(1'b1);
      thread_done = 8'h04;
      push(8'h04, 8'h00, 3'd2, 0);
      push(8'h04, 8'h04, 3'd2, GAP + 1);
      tick(2);
      thread_done = '0;
      wait_drain("t6_setwins_drain", 20);

      // Asynchronous reset in the middle of a transfer
      do_reset(1'b1);
      thread_done = 8'h32;
      df_wr       = 8'h02;
      push(8'h02, 8'h00, 3'd1, 0);
      tick(1);
      thread_done = '0;
      tick(1);
      chk("t6_pre_owner", 64'(m_cur), 64'd1);
      chk("t6_pre_wr", 64'(m_wr), 64'd1);
      #6;
      reset = 1'b0;
      #1;
      chk("t6_rst_start_read", 64'(m_sr), 64'd0);
      chk("t6_rst_out_wr", 64'(m_wr), 64'd0);
      chk("t6_rst_cur", 64'(m_cur), 64'd0);
      chk("t6_rst_owner_valid", 64'(m_ov), 64'd0);
      chk("t6_rst_out_data", m_data, 64'd0);
      tick(1);
      reset    = 1'b1;
      last_cyc = cyc;
      tick(8);
      chk("t6_pending_dropped", 64'(m_ov), 64'd0);
      df_wr = '0;

      chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
